// File: rtl/mdu_unit_pkg.sv
// Shared defines: ALU op codes, M-extension funct3 codes and MDU FSM states.
package mdu_unit_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b1000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SRA  = 4'b1101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111
   } alu_op_e;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   function automatic logic is_div(input mdu_op_e op);
      return op[2];
   endfunction

   function automatic logic is_signed_div(input mdu_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Issue/result handshake between reservation station, MDU and CDB.
interface mdu_unit_if #(
   parameter int XLEN = 32,
   parameter int RBW  = 4
);
   logic            ins_flag;
   logic [2:0]      op;
   logic [XLEN-1:0] val1;
   logic [XLEN-1:0] val2;
   logic [RBW-1:0]  ROB_idx;
   logic            busy;
   logic            val_flag;
   logic [RBW-1:0]  val_idx;
   logic [XLEN-1:0] val;
   logic            cdb_ack;

   modport slave (
      input  ins_flag, op, val1, val2, ROB_idx, cdb_ack,
      output busy, val_flag, val_idx, val
   );

   modport master (
      output ins_flag, op, val1, val2, ROB_idx, cdb_ack,
      input  busy, val_flag, val_idx, val
   );
endinterface

// File: rtl/mdu_unit_div_iter.sv
// One restoring-division step: shift next dividend bit into the partial
// remainder, subtract the divisor if it fits, shift the quotient bit in.
module mdu_div_iter #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quot_in,
   input  logic [XLEN-1:0] dvs,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quot_out
);
   logic [XLEN:0]   trial;
   logic [XLEN-1:0] diff;

   // Trial subtraction; remainder stays below the divisor so diff fits XLEN bits.
   always_comb begin
      trial = {rem_in, quot_in[XLEN-1]};
      diff  = trial[XLEN-1:0] - dvs;
      if (trial >= {1'b0, dvs}) begin
         rem_out  = diff;
         quot_out = {quot_in[XLEN-2:0], 1'b1};
      end else begin
         rem_out  = trial[XLEN-1:0];
         quot_out = {quot_in[XLEN-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/mdu_unit.sv
// RV32M multiply/divide unit: 2-cycle multiply, XLEN-step restoring divide,
// result held for the CDB until acknowledged.
module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int RBW           = 4,
   parameter bit SIGNED_MUL_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jp_wrong,
   mdu_unit_if.slave   bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e        state, state_nx;
   mdu_op_e           op_q, op_in;
   logic [XLEN-1:0]   a_q, b_q, rem_q, quot_q, dvs_q;
   logic [2*XLEN-1:0] prod_q, prod_nx;
   logic [RBW-1:0]    idx_q;
   logic [CW-1:0]     cnt_q;
   logic              neg_quot_q, neg_rem_q;

   logic              accept, sdiv_in, div_zero, div_ovf, last_iter;
   logic              a_sgn, b_sgn;
   logic [XLEN-1:0]   mag1, mag2, rem_nx, quot_nx, result;

   mdu_div_iter #(.XLEN(XLEN)) u_iter (
      .rem_in   (rem_q),
      .quot_in  (quot_q),
      .dvs      (dvs_q),
      .rem_out  (rem_nx),
      .quot_out (quot_nx)
   );

   // Decode of the incoming request and the divider's special cases.
   always_comb begin
      op_in     = mdu_op_e'(bus.op);
      accept    = rdy && !jp_wrong && bus.ins_flag && (state == ST_IDLE);
      sdiv_in   = is_signed_div(op_in);
      div_zero  = (bus.val2 == '0);
      div_ovf   = sdiv_in && (bus.val1 == MIN_NEG) && (bus.val2 == '1);
      mag1      = (sdiv_in && bus.val1[XLEN-1]) ? -bus.val1 : bus.val1;
      mag2      = (sdiv_in && bus.val2[XLEN-1]) ? -bus.val2 : bus.val2;
      last_iter = (cnt_q == CW'(XLEN-1));
   end

   // Full-width product; operand extension chosen by the latched op.
   always_comb begin
      a_sgn   = SIGNED_MUL_EN && ((op_q == OP_MULH) || (op_q == OP_MULHSU));
      b_sgn   = SIGNED_MUL_EN && (op_q == OP_MULH);
      prod_nx = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q} * {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   // Next state; flush outranks accept and ack, rdy low freezes everything.
   always_comb begin
      state_nx = state;
      if (rdy) begin
         if (jp_wrong) begin
            state_nx = ST_IDLE;
         end else begin
            unique case (state)
               ST_IDLE: if (bus.ins_flag) begin
                  if (!is_div(op_in))         state_nx = ST_MUL;
                  else if (div_zero || div_ovf) state_nx = ST_DONE;
                  else                        state_nx = ST_DIV;
               end
               ST_MUL:  state_nx = ST_DONE;
               ST_DIV:  if (last_iter) state_nx = ST_DONE;
               ST_DONE: if (bus.cdb_ack) state_nx = ST_IDLE;
               default: state_nx = ST_IDLE;
            endcase
         end
      end
   end

   // Datapath: latch request on accept, then multiply or iterate the divider.
   // Divide runs on magnitudes; signs are applied on the final step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q       <= OP_MUL;
         a_q        <= '0;
         b_q        <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         dvs_q      <= '0;
         prod_q     <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
      end else if (rdy) begin
         if (accept) begin
            op_q       <= op_in;
            a_q        <= bus.val1;
            b_q        <= bus.val2;
            idx_q      <= bus.ROB_idx;
            cnt_q      <= '0;
            dvs_q      <= mag2;
            neg_quot_q <= sdiv_in && (bus.val1[XLEN-1] ^ bus.val2[XLEN-1]);
            neg_rem_q  <= sdiv_in && bus.val1[XLEN-1];
            if (div_zero) begin
               quot_q <= '1;
               rem_q  <= bus.val1;
            end else if (div_ovf) begin
               quot_q <= bus.val1;
               rem_q  <= '0;
            end else begin
               quot_q <= mag1;
               rem_q  <= '0;
            end
         end else if (state == ST_MUL) begin
            prod_q <= prod_nx;
         end else if (state == ST_DIV) begin
            cnt_q <= cnt_q + CW'(1);
            if (last_iter) begin
               quot_q <= neg_quot_q ? -quot_nx : quot_nx;
               rem_q  <= neg_rem_q  ? -rem_nx  : rem_nx;
            end else begin
               quot_q <= quot_nx;
               rem_q  <= rem_nx;
            end
         end
      end
   end

   // Result select and CDB outputs, zero outside DONE.
   always_comb begin
      unique case (op_q)
         OP_MUL:                         result = prod_q[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:   result = prod_q[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:                result = quot_q;
         default:                        result = rem_q;
      endcase
      bus.busy     = (state != ST_IDLE);
      bus.val_flag = (state == ST_DONE);
      bus.val_idx  = (state == ST_DONE) ? idx_q  : '0;
      bus.val      = (state == ST_DONE) ? result : '0;
   end
endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter RBW, default 4, ROB index width.
REQ-003 Parameter SIGNED_MUL_EN, default 1; 0 makes MULH/MULHSU return MULHU result.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 rdy  in  1  global enable; low freezes all state and outputs.
REQ-007 jp_wrong  in  1  misprediction flush.
REQ-008 ins_flag  in  1  RS presents an M-extension op this cycle.
REQ-009 op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 val1, val2  in  XLEN  rs1/rs2 operands.
REQ-011 ROB_idx  in  RBW  destination ROB entry.
REQ-012 busy  out  1  unit not in IDLE; RS SHALL NOT issue while high.
REQ-013 val_flag  out  1  result valid for CDB.
REQ-014 val_idx  out  RBW  ROB entry of result.
REQ-015 val  out  XLEN  result.
REQ-016 cdb_ack  in  1  CDB consumed the result this cycle.

Function
REQ-017 Registered FSM, states IDLE, MUL, DIV, DONE; busy = (state != IDLE).
REQ-018 Accept: rdy & ins_flag & IDLE & !jp_wrong; latches op, operands, ROB_idx; ins_flag while busy is ignored.
REQ-019 MUL path: IDLE -> MUL (full 2*XLEN product registered) -> DONE; val_flag high 2 cycles after accept edge.
REQ-020 MUL returns product[XLEN-1:0]; MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned, each returning product[2*XLEN-1:XLEN].
REQ-021 DIV path: restoring, one quotient bit per cycle, XLEN iterations with counter 0..XLEN-1, then DONE; val_flag high XLEN+1 cycles after accept edge.
REQ-022 Signed ops divide magnitudes; quotient negated if operand signs differ; remainder takes dividend sign.
REQ-023 Divisor zero: IDLE -> DONE directly; quotient all-ones, remainder = val1; valid 1 cycle after accept.
REQ-024 Signed overflow (val1 = 1 followed by XLEN-1 zeros, val2 = all-ones, DIV/REM): IDLE -> DONE directly; quotient = val1, remainder 0.
REQ-025 DONE holds val_flag, val_idx, val stable until cdb_ack & rdy, then -> IDLE with val_flag low next cycle.
REQ-026 No new accept in the cycle of the ack; earliest next accept is the following cycle.
REQ-027 jp_wrong & rdy in any state: -> IDLE next edge, val_flag low, result discarded; beats simultaneous accept or ack.
REQ-028 Outside DONE: val_flag 0, val_idx 0, val 0.
REQ-029 rdy low: FSM, counter, datapath registers hold; jp_wrong and cdb_ack ignored that cycle.

Reset
REQ-030 rst low asynchronously forces IDLE, counter 0, busy 0, val_flag 0, val_idx 0, val 0, operand registers 0.
REQ-031 Reset mid-division or in DONE drops the operation; no result emitted after release.

Structure
REQ-032 Op funct3 codes and FSM state encodings SHALL live in the shared defines package beside the ALU op codes.
REQ-033 Divider iteration SHALL be one sub-module, mdu_div_iter (combinational single restoring step: remainder/quotient in, next remainder/quotient out).

Verification
REQ-034 MUL 7 x -3 (XLEN 32), ROB 5 -> val 0xFFFFFFEB, val_idx 5, val_flag exactly 2 cycles after accept.
REQ-035 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 2 -> 0xFFFFFFFF.
REQ-036 DIV -7 / 2 -> 0xFFFFFFFD after 33 cycles; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14.
REQ-037 DIVU 5 / 0 -> 0xFFFFFFFF, REMU 5 % 0 -> 5, DIV 0x80000000 / -1 -> 0x80000000; each valid 1 cycle after accept.
REQ-038 jp_wrong at iteration 10 of DIV -> IDLE next cycle, no val_flag; new MUL 3 x 4 one cycle later -> 12.
REQ-039 cdb_ack held low 5 cycles in DONE -> outputs stable; rdy low 3 cycles mid-DIV extends latency by exactly 3; async rst mid-DIV -> all outputs 0 immediately.
